if_stage: RTL

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage_pkg.sv | 43 ++++
 rtl/if_resp_fifo.sv | 61 ++++++
 rtl/if_stage.sv | 139 +++++++++++++
 3 files changed

// File: rtl/if_stage_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | if_stage_pkg : shared fetch widths, RV32 field positions and opcodes.  |
// | Revision     : 1.0                                                     |
// +------------------------------------------------------------------------+
package if_stage_pkg;

  localparam int XLEN = 32;

  // Instruction field bit positions, shared with the decoder
  localparam int C_OPCODE_LSB  = 0;
  localparam int C_OPCODE_MSB  = 6;
  localparam int C_RD_LSB      = 7;
  localparam int C_RD_MSB      = 11;
  localparam int C_FUNCT3_LSB  = 12;
  localparam int C_FUNCT3_MSB  = 14;
  localparam int C_RS1_LSB     = 15;
  localparam int C_RS1_MSB     = 19;
  localparam int C_RS2_LSB     = 20;
  localparam int C_RS2_MSB     = 24;
  localparam int C_FUNCT7_5_BIT = 30;

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'b0000011,
    OPC_OP_IMM = 7'b0010011,
    OPC_AUIPC  = 7'b0010111,
    OPC_STORE  = 7'b0100011,
    OPC_OP     = 7'b0110011,
    OPC_LUI    = 7'b0110111,
    OPC_BRANCH = 7'b1100011,
    OPC_JALR   = 7'b1100111,
    OPC_JAL    = 7'b1101111,
    OPC_SYSTEM = 7'b1110011
  } opcode_e;

  // Response FIFO sizing
  localparam int                      C_FIFO_CNT_W = 2;
  localparam logic [C_FIFO_CNT_W-1:0] C_FIFO_DEPTH = 2;
  localparam logic [C_FIFO_CNT_W-1:0] C_FIFO_ONE   = 1;
  localparam logic [C_FIFO_CNT_W:0]   C_OCC_LIMIT  = 2;

endpackage
`default_nettype wire

// File: rtl/if_resp_fifo.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | if_resp_fifo : 2-entry fetch response FIFO with flush.                 |
// | Revision     : 1.0                                                     |
// +------------------------------------------------------------------------+
module if_resp_fifo
  import if_stage_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [WIDTH-1:0]        push_data,
  input  logic                    pop,
  input  logic                    flush,
  output logic [WIDTH-1:0]        head_data,
  output logic                    full,
  output logic                    empty,
  output logic [C_FIFO_CNT_W-1:0] count
);

  logic [WIDTH-1:0]        r_mem [0:1];
  logic                    r_rd_ptr;
  logic                    r_wr_ptr;
  logic [C_FIFO_CNT_W-1:0] r_count;
  logic                    w_do_pop;
  logic                    w_do_push;

  assign w_do_pop  = pop & (r_count != '0);
  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign w_do_push = push & ((r_count != C_FIFO_DEPTH) | w_do_pop);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= push_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_do_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + C_FIFO_ONE;
        2'b01:   r_count <= r_count - C_FIFO_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  assign head_data = r_mem[r_rd_ptr];
  assign full      = (r_count == C_FIFO_DEPTH);
  assign empty     = (r_count == '0);
  assign count     = r_count;

endmodule
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | if_stage : instruction fetch with 1-cycle imem and 2-entry skid FIFO.  |
// | Optional macro IF_PERF_CNT_EN adds perf_fetched / perf_stall counters. |
// | Revision : 1.0                                                         |
// +------------------------------------------------------------------------+
module if_stage #(
  parameter int              XLEN     = if_stage_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_pc_plus4,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_funct3,
  output logic            out_funct7_5
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_stall
`endif
);

  import if_stage_pkg::*;

  localparam logic [XLEN-1:0] C_PC_STEP          = XLEN'(4);
  localparam logic [XLEN-1:0] C_RESET_PC_ALIGNED = {RESET_PC[XLEN-1:2], 2'b00};

  logic [XLEN-1:0]         r_pc;
  logic [XLEN-1:0]         r_req_pc;
  logic                    r_inflight;

  logic [XLEN-1:0]         w_target;
  logic [XLEN-1:0]         w_fetch_addr;
  logic                    w_req;
  logic                    w_pop;
  logic                    w_push;
  logic [C_FIFO_CNT_W:0]   w_occupancy;
  logic [C_FIFO_CNT_W:0]   w_occ_after_pop;
  logic [2*XLEN-1:0]       w_head;
  logic [XLEN-1:0]         w_head_pc;
  logic [XLEN-1:0]         w_head_instr;
  logic                    w_fifo_full;
  logic                    w_fifo_empty;
  logic [C_FIFO_CNT_W-1:0] w_fifo_count;
  logic                    w_unused_ok;

  assign w_target     = {redirect_pc[XLEN-1:2], 2'b00};
  assign w_fetch_addr = redirect_valid ? w_target : r_pc;

  assign out_valid = ~w_fifo_empty & ~rst;
  assign w_pop     = out_valid & out_ready;

  // The response landing in a redirect cycle belongs to the old path
  assign w_push = r_inflight & ~redirect_valid;

  assign w_occupancy     = {1'b0, w_fifo_count} + {{C_FIFO_CNT_W{1'b0}}, r_inflight};
  assign w_occ_after_pop = w_occupancy - {{C_FIFO_CNT_W{1'b0}}, w_pop};

  // A redirect flushes everything, so its target always has room
  assign w_req = ~rst & (redirect_valid | (w_occ_after_pop < C_OCC_LIMIT));

  assign imem_req  = w_req;
  assign imem_addr = w_fetch_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= C_RESET_PC_ALIGNED;
      r_req_pc   <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_req;
      if (w_req) begin
        r_pc     <= w_fetch_addr + C_PC_STEP;
        r_req_pc <= w_fetch_addr;
      end
    end
  end

  if_resp_fifo #(
    .WIDTH (2*XLEN)
  ) u_resp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data ({r_req_pc, imem_rdata}),
    .pop       (w_pop),
    .flush     (redirect_valid),
    .head_data (w_head),
    .full      (w_fifo_full),
    .empty     (w_fifo_empty),
    .count     (w_fifo_count)
  );

  assign w_head_pc    = w_head[2*XLEN-1:XLEN];
  assign w_head_instr = w_head[XLEN-1:0];

  assign out_instr    = w_head_instr;
  assign out_pc       = w_head_pc;
  assign out_pc_plus4 = w_head_pc + C_PC_STEP;
  assign out_opcode   = w_head_instr[C_OPCODE_MSB:C_OPCODE_LSB];
  assign out_funct3   = w_head_instr[C_FUNCT3_MSB:C_FUNCT3_LSB];
  assign out_funct7_5 = w_head_instr[C_FUNCT7_5_BIT];

  assign w_unused_ok = &{1'b0, redirect_pc[1:0], w_fifo_full};

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_fetched <= '0;
      r_perf_stall   <= '0;
    end else begin
      if (w_pop) begin
        r_perf_fetched <= r_perf_fetched + 32'd1;
      end
      if (out_valid & ~out_ready) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_stall   = r_perf_stall;
`endif

endmodule
`default_nettype wire
